msi_directory: RTL

MSI_DIRECTORY -- requirements
Module: msi_directory

---
 rtl/msi_dir_pkg.sv | 18 +
 rtl/msi_dir_alloc.sv | 26 ++
 rtl/msi_directory.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/msi_dir_pkg.sv
// Shared encodings for the MSI directory: entry states, request codes, FSM states.
package msi_dir_pkg;

    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_I     = 2'b01;
    localparam logic [1:0] ST_S     = 2'b10;
    localparam logic [1:0] ST_M     = 2'b11;

    localparam logic [1:0] REQ_RD   = 2'b00;
    localparam logic [1:0] REQ_WR   = 2'b01;
    localparam logic [1:0] REQ_WB   = 2'b10;
    localparam logic [1:0] REQ_RSVD = 2'b11;

    typedef enum logic [2:0] {
        IDLE, LOOKUP, EVICT, MEMWR, MEMRD, PROBE, RESP
    } fsmState_t;

endpackage

// File: rtl/msi_dir_alloc.sv
// Picks the slot for a directory miss: lowest-index empty entry, else the round-robin victim.
module msi_dir_alloc
    import msi_dir_pkg::*;
#(
    parameter int ENTRIES = 4,
    parameter int IW      = 2
) (
    input  logic [2*ENTRIES-1:0] entryStates,
    input  logic [IW-1:0]        rrPtr,
    output logic [IW-1:0]        allocIdx,
    output logic                 allocEmpty
);

    always_comb begin
        allocEmpty = 1'b0;
        allocIdx   = rrPtr;
        // Descending scan so the lowest empty index wins.
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (entryStates[2*i +: 2] == ST_EMPTY) begin
                allocEmpty = 1'b1;
                allocIdx   = IW'(i);
            end
        end
    end

endmodule

// File: rtl/msi_directory.sv
// Fully associative MSI directory: one request at a time, probes sharers/owner and
// fetches or writes back memory as needed; response is a one-cycle RespValid pulse.
module msi_directory
    import msi_dir_pkg::*;
#(
    parameter int NPROC   = 2,
    parameter int ENTRIES = 4,
    parameter int AW      = 4,
    parameter int DW      = 4
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     ReqValid,
    output logic                     ReqReady,
    input  logic [1:0]               ReqType,
    input  logic [$clog2(NPROC)-1:0] ReqProc,
    input  logic [AW-1:0]            ReqAddr,
    input  logic [DW-1:0]            ReqData,
    output logic                     ProbeValid,
    output logic [NPROC-1:0]         ProbeMask,
    output logic                     ProbeInv,
    input  logic                     ProbeAck,
    input  logic [DW-1:0]            ProbeData,
    output logic                     MemValid,
    output logic                     MemWrite,
    output logic [AW-1:0]            MemAddr,
    output logic [DW-1:0]            MemWdata,
    input  logic                     MemAck,
    input  logic [DW-1:0]            MemRdata,
    output logic                     RespValid,
    output logic                     RespErr,
    output logic [DW-1:0]            RespData,
    output logic [1:0]               RespState,
    output logic [NPROC-1:0]         RespSharers
);

    localparam int IW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    logic [ENTRIES-1:0][AW-1:0]    eAddr;
    logic [ENTRIES-1:0][1:0]       eState;
    logic [ENTRIES-1:0][DW-1:0]    eData;
    logic [ENTRIES-1:0][NPROC-1:0] eShr;

    fsmState_t                fsm;
    logic [1:0]               rType;
    logic [$clog2(NPROC)-1:0] rProc;
    logic [AW-1:0]            rAddr;
    logic [DW-1:0]            rData;
    logic [IW-1:0]            rrPtr, allocIdx, hitIdx, tIdx;
    logic                     allocEmpty, hit, evicting, oldM, fillAfter;
    logic [NPROC-1:0]         reqBit, others;

    msi_dir_alloc #(.ENTRIES(ENTRIES), .IW(IW)) uAlloc (
        .entryStates(eState),
        .rrPtr      (rrPtr),
        .allocIdx   (allocIdx),
        .allocEmpty (allocEmpty)
    );

    always_comb begin
        hit    = 1'b0;
        hitIdx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (eState[i] != ST_EMPTY && eAddr[i] == rAddr) begin
                hit    = 1'b1;
                hitIdx = IW'(i);
            end
        end
    end

    assign reqBit = NPROC'(1) << rProc;
    assign others = eShr[hitIdx] & ~reqBit;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            eAddr <= '0; eState <= '0; eData <= '0; eShr <= '0;
            fsm <= IDLE; rrPtr <= '0; tIdx <= '0;
            rType <= '0; rProc <= '0; rAddr <= '0; rData <= '0;
            evicting <= 1'b0; oldM <= 1'b0; fillAfter <= 1'b0;
            ReqReady <= 1'b1;
            ProbeValid <= 1'b0; ProbeMask <= '0; ProbeInv <= 1'b0;
            MemValid <= 1'b0; MemWrite <= 1'b0; MemAddr <= '0; MemWdata <= '0;
            RespValid <= 1'b0; RespErr <= 1'b0; RespData <= '0;
            RespState <= ST_EMPTY; RespSharers <= '0;
        end else begin
            case (fsm)
                IDLE: if (ReqValid) begin
                    rType <= ReqType; rProc <= ReqProc; rAddr <= ReqAddr; rData <= ReqData;
                    ReqReady <= 1'b0;
                    fsm <= LOOKUP;
                end
                LOOKUP: begin
                    RespErr <= 1'b0; RespData <= '0; RespState <= ST_EMPTY; RespSharers <= '0;
                    RespValid <= 1'b1;
                    fsm <= RESP;
                    if (rType == REQ_RSVD) begin
                        RespErr <= 1'b1;
                    end else if (rType == REQ_WB) begin
                        if (hit && eState[hitIdx] == ST_M && eShr[hitIdx] == reqBit) begin
                            eData[hitIdx] <= rData; eState[hitIdx] <= ST_I; eShr[hitIdx] <= '0;
                            RespData <= rData; RespState <= ST_I;
                            MemValid <= 1'b1; MemWrite <= 1'b1; MemAddr <= rAddr; MemWdata <= rData;
                            fillAfter <= 1'b0; RespValid <= 1'b0; fsm <= MEMWR;
                        end else begin
                            RespErr <= 1'b1;
                        end
                    end else if (hit) begin
                        tIdx <= hitIdx; oldM <= (eState[hitIdx] == ST_M); evicting <= 1'b0;
                        if (rType == REQ_RD && eState[hitIdx] == ST_M && eShr[hitIdx] != reqBit) begin
                            ProbeValid <= 1'b1; ProbeMask <= eShr[hitIdx]; ProbeInv <= 1'b0;
                            RespValid <= 1'b0; fsm <= PROBE;
                        end else if (rType == REQ_RD && eState[hitIdx] == ST_M) begin
                            RespData <= eData[hitIdx]; RespState <= ST_M; RespSharers <= eShr[hitIdx];
                        end else if (rType == REQ_RD) begin
                            eState[hitIdx] <= ST_S; eShr[hitIdx] <= eShr[hitIdx] | reqBit;
                            RespData <= eData[hitIdx]; RespState <= ST_S;
                            RespSharers <= eShr[hitIdx] | reqBit;
                        end else if (others != '0) begin
                            ProbeValid <= 1'b1; ProbeMask <= others; ProbeInv <= 1'b1;
                            RespValid <= 1'b0; fsm <= PROBE;
                        end else begin
                            eState[hitIdx] <= ST_M; eShr[hitIdx] <= reqBit;
                            RespData <= eData[hitIdx]; RespState <= ST_M; RespSharers <= reqBit;
                        end
                    end else begin
                        tIdx <= allocIdx; evicting <= !allocEmpty; RespValid <= 1'b0;
                        if (allocEmpty) begin
                            MemValid <= 1'b1; MemWrite <= 1'b0; MemAddr <= rAddr; fsm <= MEMRD;
                        end else begin
                            rrPtr <= (rrPtr == IW'(ENTRIES - 1)) ? '0 : rrPtr + 1'b1;
                            fsm <= EVICT;
                        end
                    end
                end
                EVICT: begin
                    oldM <= (eState[tIdx] == ST_M);
                    if (eShr[tIdx] != '0) begin
                        ProbeValid <= 1'b1; ProbeMask <= eShr[tIdx]; ProbeInv <= 1'b1; fsm <= PROBE;
                    end else begin
                        MemValid <= 1'b1; MemWrite <= 1'b0; MemAddr <= rAddr; fsm <= MEMRD;
                    end
                end
                PROBE: if (ProbeAck) begin
                    ProbeValid <= 1'b0; ProbeMask <= '0; ProbeInv <= 1'b0;
                    if (!ProbeInv) begin
                        // Downgrade: owner's dirty data goes to the entry and to memory.
                        eData[tIdx] <= ProbeData; eState[tIdx] <= ST_S;
                        eShr[tIdx] <= eShr[tIdx] | reqBit;
                        RespData <= ProbeData; RespState <= ST_S; RespSharers <= eShr[tIdx] | reqBit;
                        MemValid <= 1'b1; MemWrite <= 1'b1; MemAddr <= rAddr; MemWdata <= ProbeData;
                        fillAfter <= 1'b0; fsm <= MEMWR;
                    end else if (evicting && oldM) begin
                        MemValid <= 1'b1; MemWrite <= 1'b1; MemAddr <= eAddr[tIdx]; MemWdata <= ProbeData;
                        fillAfter <= 1'b1; fsm <= MEMWR;
                    end else if (evicting) begin
                        MemValid <= 1'b1; MemWrite <= 1'b0; MemAddr <= rAddr; fsm <= MEMRD;
                    end else begin
                        eData[tIdx] <= oldM ? ProbeData : eData[tIdx];
                        eState[tIdx] <= ST_M; eShr[tIdx] <= reqBit;
                        RespData <= oldM ? ProbeData : eData[tIdx];
                        RespState <= ST_M; RespSharers <= reqBit;
                        RespValid <= 1'b1; fsm <= RESP;
                    end
                end
                MEMWR: if (MemAck) begin
                    MemWrite <= 1'b0;
                    if (fillAfter) begin
                        MemAddr <= rAddr; MemWdata <= '0; fsm <= MEMRD;
                    end else begin
                        MemValid <= 1'b0; RespValid <= 1'b1; fsm <= RESP;
                    end
                end
                MEMRD: if (MemAck) begin
                    MemValid <= 1'b0;
                    eAddr[tIdx] <= rAddr; eData[tIdx] <= MemRdata; eShr[tIdx] <= reqBit;
                    eState[tIdx] <= (rType == REQ_WR) ? ST_M : ST_S;
                    RespErr <= 1'b0; RespData <= MemRdata; RespSharers <= reqBit;
                    RespState <= (rType == REQ_WR) ? ST_M : ST_S;
                    RespValid <= 1'b1; fsm <= RESP;
                end
                RESP: begin
                    RespValid <= 1'b0; RespErr <= 1'b0; ReqReady <= 1'b1; fsm <= IDLE;
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule
